// File: rtl/base_sampler_rand_feeder.sv
// base_sampler_rand_feeder: packs the 64-bit PRNG word stream into 72-bit
// words for the base sampler. Bits are buffered LSB-first in a 136-bit
// accumulator; the valid bits always sit at acc_q[cnt_q-1:0] and every bit
// above cnt_q is held at zero.
//
// Handshake semantics (both sides): a word moves on a rising edge exactly
// when valid and ready are both 1 in the cycle before that edge. The
// producer holds data stable while valid is high and ready is low.
// rand_72_valid_o does not depend on rand_72_ready_i. rand_64_ready_o
// depends on rand_72_ready_i through one combinational path, because a
// guaranteed pop frees room for a push when the buffer is above 72 bits.
module base_sampler_rand_feeder #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 72,
  parameter int BUF_W = 136
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [IN_W-1:0]   rand_64_i,
  input  logic              rand_64_valid_i,
  output logic              rand_64_ready_o,
  output logic [OUT_W-1:0]  rand_72_o,
  output logic              rand_72_valid_o,
  input  logic              rand_72_ready_i,
  output logic [7:0]        fill_o
);

  logic [BUF_W-1:0] acc_q;
  logic [BUF_W-1:0] acc_d;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] wide_in;
  logic [BUF_W-1:0] ins;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic [7:0]       base;
  logic             valid_q;
  logic             pop;
  logic             push;

  // Room exists if at most 72 bits are held, or if a pop this cycle frees 72.
  assign rand_64_ready_o = (cnt_q <= 8'd72) | rand_72_ready_i;

  assign rand_72_o       = acc_q[OUT_W-1:0];
  assign rand_72_valid_o = valid_q;
  assign fill_o          = cnt_q;

  // Next-state datapath: optional 72-bit drop, then insert at one of 9 offsets.
  always_comb begin
    pop     = valid_q & rand_72_ready_i;
    push    = rand_64_valid_i & rand_64_ready_o;
    shifted = pop ? (acc_q >> OUT_W) : acc_q;
    base    = pop ? (cnt_q - 8'd72) : cnt_q;
    wide_in = {{(BUF_W-IN_W){1'b0}}, rand_64_i};
    ins     = '0;
    // A push only happens with base <= 72, so offsets above 72 cannot occur.
    case (base[7:3])
      5'd0:    ins = wide_in;
      5'd1:    ins = wide_in << 8;
      5'd2:    ins = wide_in << 16;
      5'd3:    ins = wide_in << 24;
      5'd4:    ins = wide_in << 32;
      5'd5:    ins = wide_in << 40;
      5'd6:    ins = wide_in << 48;
      5'd7:    ins = wide_in << 56;
      5'd8:    ins = wide_in << 64;
      5'd9:    ins = wide_in << 72;
      default: ins = '0;
    endcase
    // Bits above base are zero, so OR-ing in the new word is an insert.
    acc_d = push ? (shifted | ins) : shifted;
    cnt_d = push ? (base + 8'd64) : base;
  end

  // Accumulator, count and registered output-valid; rst beats flush_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d >= 8'd72);
    end
  end

endmodule

// File: tb/tb_base_sampler_rand_feeder.sv
// Directed bench for base_sampler_rand_feeder. A bit-level reference model
// re-chunks every accepted input word into expected 72-bit words held in a
// queue; each accepted output word is compared against the queue head.
module tb_base_sampler_rand_feeder;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic [63:0] rand_64_i;
  logic        rand_64_valid_i;
  logic        rand_64_ready_o;
  logic [71:0] rand_72_o;
  logic        rand_72_valid_o;
  logic        rand_72_ready_i;
  logic [7:0]  fill_o;

  base_sampler_rand_feeder dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .rand_64_i       (rand_64_i),
    .rand_64_valid_i (rand_64_valid_i),
    .rand_64_ready_o (rand_64_ready_o),
    .rand_72_o       (rand_72_o),
    .rand_72_valid_o (rand_72_valid_o),
    .rand_72_ready_i (rand_72_ready_i),
    .fill_o          (fill_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [71:0]  exp_q[$];
  logic [135:0] pend;
  int           pend_n;
  int           n_chk;
  int           n_fail;
  logic         last_pop;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_fill();
    return pend_n + 72 * exp_q.size();
  endfunction

  task automatic model_clear();
    exp_q.delete();
    pend   = '0;
    pend_n = 0;
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs against the model,
  // update the scoreboard for the handshakes that fire, then cross the edge.
  task automatic step(input logic vin, input logic [63:0] din, input logic rdy,
                      input logic fl, input logic rs);
    logic        m_pop;
    logic        m_push;
    logic        m_ready;
    logic [71:0] w;
    int          mf;
    rand_64_valid_i = vin;
    rand_64_i       = din;
    rand_72_ready_i = rdy;
    flush_i         = fl;
    rst             = rs;
    #1;
    mf      = model_fill();
    m_ready = (mf <= 72) | rdy;
    m_pop   = (exp_q.size() != 0) & rdy;
    m_push  = vin & m_ready;
    chk("fill", {128'b0, fill_o}, 136'(mf));
    chk("valid", {135'b0, rand_72_valid_o}, {135'b0, exp_q.size() != 0});
    chk("ready", {135'b0, rand_64_ready_o}, {135'b0, m_ready});
    if (m_pop) begin
      w = exp_q.pop_front();
      chk("data", {64'b0, rand_72_o}, {64'b0, w});
    end
    if (m_push) begin
      pend = pend | ({72'b0, din} << pend_n);
      pend_n += 64;
      while (pend_n >= 72) begin
        exp_q.push_back(pend[71:0]);
        pend = pend >> 72;
        pend_n -= 72;
      end
    end
    if (fl || rs) model_clear();
    last_pop = m_pop;
    @(posedge clk);
    #1;
  endtask

  // Directed sequence
  initial begin
    logic [63:0] lfsr;
    logic [71:0] held;
    int          win_pops;
    n_chk    = 0;
    n_fail   = 0;
    last_pop = 1'b0;
    model_clear();
    rst             = 1'b1;
    flush_i         = 1'b0;
    rand_64_i       = '0;
    rand_64_valid_i = 1'b0;
    rand_72_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values, then idle for 5 cycles.
    chk("rst_valid", {135'b0, rand_72_valid_o}, 136'd0);
    chk("rst_data", {64'b0, rand_72_o}, 136'd0);
    chk("rst_fill", {128'b0, fill_o}, 136'd0);
    chk("rst_ready", {135'b0, rand_64_ready_o}, 136'd1);
    repeat (5) step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Two known words -> first output word.
    step(1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'hFEDCBA9876543210, 1'b1, 1'b0, 1'b0);
    chk("first_word", {64'b0, rand_72_o}, {64'b0, 72'h100123456789ABCDEF});
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk("fill_56", {128'b0, fill_o}, 136'd56);
    step(1'b1, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("residue", {64'b0, rand_72_o}, {64'b0, 72'h0000FEDCBA98765432});
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);

    // Continuous stream, both sides ready: 8 pops in every 9-cycle window.
    lfsr = 64'h9E3779B97F4A7C15;
    step(1'b1, lfsr, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 99; k++) begin
      win_pops = 0;
      for (int j = 0; j < 9; j++) begin
        lfsr = lfsr ^ (lfsr << 13);
        lfsr = lfsr ^ (lfsr >> 7);
        lfsr = lfsr ^ (lfsr << 17);
        step(1'b1, lfsr, 1'b1, 1'b0, 1'b0);
        if (last_pop) win_pops++;
      end
      chk("window_pops", 136'(win_pops), 136'd8);
    end
    for (int j = 0; j < 8; j++) step(1'b1, 64'(j) * 64'h0101010101010101, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);

    // Output stall: fill to 128, input blocked, held word stable.
    step(1'b1, 64'hA5A5A5A5_5A5A5A5A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h1122334455667788, 1'b0, 1'b0, 1'b0);
    held = 72'h88A5A5A5A55A5A5A5A;
    chk("stall_fill", {128'b0, fill_o}, 136'd128);
    chk("stall_ready", {135'b0, rand_64_ready_o}, 136'd0);
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 64'hDEADBEEF_00000000 + 64'(j), 1'b0, 1'b0, 1'b0);
      chk("stall_hold", {64'b0, rand_72_o}, {64'b0, held});
    end
    step(1'b1, 64'hCAFEF00D12345678, 1'b1, 1'b0, 1'b0);
    chk("release_fill", {128'b0, fill_o}, 136'd120);

    // Flush at 120 with simultaneous push and pop.
    step(1'b1, 64'h0BADC0DE0BADC0DE, 1'b1, 1'b1, 1'b0);
    chk("flush_fill", {128'b0, fill_o}, 136'd0);
    chk("flush_valid", {135'b0, rand_72_valid_o}, 136'd0);
    step(1'b1, 64'h1357924680ACE0F1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'hFFEEDDCCBBAA99C3, 1'b1, 1'b0, 1'b0);
    chk("post_flush_word", {64'b0, rand_72_o}, {64'b0, 72'hC31357924680ACE0F1});
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);

    // Reach 104 with the output stalled, then reset mid-stream.
    step(1'b1, 64'h00000000_00000001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h00000000_00000002, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h00000000_00000003, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'h00000000_00000004, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'h00000000_00000005, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_fill", {128'b0, fill_o}, 136'd104);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h77, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_valid", {135'b0, rand_72_valid_o}, 136'd0);
    chk("mid_rst_data", {64'b0, rand_72_o}, 136'd0);
    chk("mid_rst_fill", {128'b0, fill_o}, 136'd0);
    chk("mid_rst_ready", {135'b0, rand_64_ready_o}, 136'd1);
    step(1'b1, 64'h2468ACE013579BDF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h00000000000000E5, 1'b0, 1'b0, 1'b0);
    chk("post_rst_word", {64'b0, rand_72_o}, {64'b0, 72'hE52468ACE013579BDF});
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
